freelist: RTL
=============

// Module: freelist
// PURPOSE
// - Rename-stage physical register free list; sits directly upstream of the dispatch busy table.
// - Hands out up to 2 free pregs per cycle. Allocated pregs drive busytable alloc_addr0/1
//   with alloc_en = alloc_req & alloc_ready.
// - Takes back up to 2 released pregs per cycle from commit (old dest mapping).
// - Keeps a speculative head and a committed head, so a pipeline flush returns all
//   uncommitted allocations in one cycle.
// PARAMETERS
// - ENTRY_COUNT  64  total physical registers; preg index width = `PREG_RANGE ([5:0])
// - ARCH_REGS    32  pregs 0..ARCH_REGS-1 hold the reset arch mapping and are never on the list at reset
// - DEPTH        ENTRY_COUNT-ARCH_REGS (32, power of 2)  list capacity; localparam
// PORTS
// - clock        in   1       clock
// - reset_n      in   1       async active-low reset
// - alloc_req0   in   1       rename slot 0 needs a dest preg
// - alloc_req1   in   1       rename slot 1 needs a dest preg
// - alloc_addr0  out  PREG    preg granted to slot 0 (combinational)
// - alloc_addr1  out  PREG    preg granted to slot 1 (combinational)
// - alloc_ready  out  1       free_count >= 2; rename stalls when low
// - free_en0     in   1       commit slot 0 releases a preg
// - free_addr0   in   PREG    preg released by commit slot 0
// - free_en1     in   1       commit slot 1 releases a preg
// - free_addr1   in   PREG    preg released by commit slot 1
// - commit_en0   in   1       commit slot 0 retires an instr that allocated a preg
// - commit_en1   in   1       commit slot 1 retires an instr that allocated a preg
// - flush        in   1       redirect; discard all uncommitted allocations
// - free_count   out  $clog2(DEPTH)+1  entries between spec_head and tail
// BEHAVIOUR
// - Storage: DEPTH x PREG circular array.
// - Pointers: spec_head, arch_head, tail; each is $clog2(DEPTH) index bits + 1 wrap bit.
// - Reset (async):
//   - entries[i] = ARCH_REGS+i
//   - spec_head = arch_head = 0
//   - tail = {wrap=1, idx=0}
//   - free_count = DEPTH (32), alloc_ready = 1
//   - alloc_addr0/1 = 32/33
// - Allocation (combinational read, pointer update at posedge):
//   - n_alloc = req0 + req1.
//   - Slot 0 reads entries[spec_head]. Slot 1 reads entries[spec_head+1] if req0, else entries[spec_head].
//   - Allocation is all-or-nothing: only when alloc_ready=1 and flush=0 does spec_head advance by n_alloc.
//   - With alloc_ready=0, requests are ignored and spec_head holds.
//   - alloc_addr outputs are don't-care when their req is 0.
// - Free (enqueue at posedge):
//   - n_free = free_en0 + free_en1. Entries are compacted: a lone free_en1 writes at tail.
//   - tail advances by n_free.
//   - A freed preg becomes allocatable the next cycle (no same-cycle bypass).
// - Commit: arch_head advances by commit_en0 + commit_en1 each cycle.
// - Flush:
//   - spec_head <= arch_head + commit_en0 + commit_en1 (same-cycle commits included).
//   - Same-cycle alloc is dropped; same-cycle frees still enqueue.
// - free_count = tail - spec_head (wrap-aware). It is registered-pointer derived, so
//   free_count and alloc_ready reflect the current-cycle state.
// - Simultaneous alloc+free: both pointers update independently; the count changes by n_free - n_alloc.
// - Wrap-around:
//   - Index wraps mod DEPTH and the wrap bit toggles.
//   - spec_head==tail with equal wrap bits means empty.
//   - Differing wrap bits with equal index means full (DEPTH).
// - Legal operation never frees more pregs than were allocated. Overflow (count > DEPTH)
//   and commit past spec_head are illegal upstream behaviour.
// - Reset mid-operation restores the reset state regardless of in-flight requests.
// CONFIGURATION
// - FREELIST_CHECK_EN defined:
//   - Adds output port fl_error (1 bit, reset 0, sticky until reset).
//   - fl_error sets on any of:
//     - free when the list is full
//     - alloc_req while alloc_ready=0 and no flush
//     - arch_head passing spec_head
//     - free_addr < ARCH_REGS
//   - Adds simulation $error messages for the same conditions.
// - FREELIST_CHECK_EN undefined: no port, no checks; the datapath is identical.
// TESTING
// - Reset, req0=req1=1 for 1 cycle -> alloc_addr0=32, alloc_addr1=33; next cycle free_count=30, addrs 34/35.
// - Only req1=1 after reset -> alloc_addr1=32; next cycle free_count=31, head entry 33.
// - 15 dual allocs (count 2) -> alloc_ready=1; one more dual -> count 0, alloc_ready=0;
//   req held -> spec_head unchanged.
// - From empty: free_en0=1 addr=40 and free_en1=1 addr=41 -> next cycle count=2, alloc_addr0=40,
//   alloc_addr1=41; wrap bit toggled correctly.
// - Alloc 6 pregs, commit_en0=1 x2, then flush with commit_en0=1 in the same cycle ->
//   spec_head = arch_head = 3, free_count = 29; next alloc returns 35.
// - Run 200 cycles of random alloc/free/commit with reference model -> free_count and addresses match;
//   with FREELIST_CHECK_EN, fl_error stays 0.

Source files
------------

// File: rtl/freelist.sv
// Rename-stage physical register free list: 2-wide allocate, 2-wide release, and a
// speculative/committed head pair for single-cycle flush recovery. Optional checks: FREELIST_CHECK_EN.
module freelist #(
  parameter  int ENTRY_COUNT = 64,
  parameter  int ARCH_REGS   = 32,
  localparam int DEPTH       = ENTRY_COUNT - ARCH_REGS,
  localparam int PREG_W      = $clog2(ENTRY_COUNT),
  localparam int IDX_W       = $clog2(DEPTH),
  localparam int PTR_W       = IDX_W + 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              alloc_req0,
  input  logic              alloc_req1,
  output logic [PREG_W-1:0] alloc_addr0,
  output logic [PREG_W-1:0] alloc_addr1,
  output logic              alloc_ready,
  input  logic              free_en0,
  input  logic [PREG_W-1:0] free_addr0,
  input  logic              free_en1,
  input  logic [PREG_W-1:0] free_addr1,
  input  logic              commit_en0,
  input  logic              commit_en1,
  input  logic              flush,
  output logic [PTR_W-1:0]  free_count
`ifdef FREELIST_CHECK_EN
  ,
  output logic              fl_error
`endif
);

  typedef logic [PTR_W-1:0] ptr_t;

  logic [PREG_W-1:0] entries [DEPTH];
  ptr_t              spec_head, arch_head, tail;

  logic [IDX_W-1:0]  head_idx, head_idx1, tail_idx, tail_idx1, wr1_idx;
  logic [1:0]        n_alloc, n_free, n_commit;
  logic              alloc_fire;

  assign head_idx  = spec_head[IDX_W-1:0];
  assign head_idx1 = head_idx + IDX_W'(1);
  assign tail_idx  = tail[IDX_W-1:0];
  assign tail_idx1 = tail_idx + IDX_W'(1);

  assign n_alloc  = {1'b0, alloc_req0} + {1'b0, alloc_req1};
  assign n_free   = {1'b0, free_en0}   + {1'b0, free_en1};
  assign n_commit = {1'b0, commit_en0} + {1'b0, commit_en1};

  // Wrap bit makes the subtraction distinguish full (DEPTH) from empty (0).
  assign free_count  = tail - spec_head;
  assign alloc_ready = (free_count >= PTR_W'(2));
  assign alloc_fire  = alloc_ready & ~flush;

  assign alloc_addr0 = entries[head_idx];
  assign alloc_addr1 = alloc_req0 ? entries[head_idx1] : entries[head_idx];

  // A lone slot-1 release is compacted down onto the tail slot.
  assign wr1_idx = free_en0 ? tail_idx1 : tail_idx;

  // NOTE: the storage is reset on purpose: the list must come up holding the
  // pregs not used by the reset architectural mapping, so each entry is a real flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= PREG_W'(ARCH_REGS + i);
      end
    end else begin
      if (free_en0) entries[tail_idx] <= free_addr0;
      if (free_en1) entries[wr1_idx]  <= free_addr1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every pointer sees the
  // pre-edge value of the others (flush reads arch_head before it moves).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spec_head <= '0;
      arch_head <= '0;
      tail      <= {1'b1, {IDX_W{1'b0}}};
    end else begin
      tail      <= tail + PTR_W'(n_free);
      arch_head <= arch_head + PTR_W'(n_commit);
      if (flush) begin
        spec_head <= arch_head + PTR_W'(n_commit);
      end else if (alloc_fire) begin
        spec_head <= spec_head + PTR_W'(n_alloc);
      end
    end
  end

`ifdef FREELIST_CHECK_EN
  localparam int CHK_W = PTR_W + 1;

  logic [CHK_W-1:0] fill_next;
  ptr_t             in_flight;
  logic             overfill, bad_alloc, bad_commit, bad_addr, err_cond;

  assign fill_next  = {1'b0, free_count} + CHK_W'(n_free);
  assign in_flight  = spec_head - arch_head;
  assign overfill   = (n_free != 2'd0) && (fill_next > CHK_W'(DEPTH));
  assign bad_alloc  = (alloc_req0 | alloc_req1) & ~alloc_ready & ~flush;
  assign bad_commit = (in_flight < PTR_W'(n_commit));
  assign bad_addr   = (free_en0 && (free_addr0 < PREG_W'(ARCH_REGS))) ||
                      (free_en1 && (free_addr1 < PREG_W'(ARCH_REGS)));
  assign err_cond   = overfill | bad_alloc | bad_commit | bad_addr;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) fl_error <= 1'b0;
    else          fl_error <= fl_error | err_cond;
  end

  always @(posedge clock) begin
    if (reset_n) begin
      assert (!overfill)   else $error("freelist: release while list full");
      assert (!bad_alloc)  else $error("freelist: alloc_req while alloc_ready low");
      assert (!bad_commit) else $error("freelist: arch_head passing spec_head");
      assert (!bad_addr)   else $error("freelist: released preg below ARCH_REGS");
    end
  end
`endif

endmodule
